// File: rtl/rr_arb8_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
// Also holds the rotating-priority pick helper used by the arbiter core.
package rr_arb8_pkg;

    localparam int N_REQ        = 8;
    localparam int IDX_W        = 3;
    localparam int HOLD_MAX_DEF = 15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit at or after ptr, wrapping 7->0; walking backwards lets the
    // lowest offset overwrite any later hit.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] ptr);
        pick_t            p;
        logic [IDX_W-1:0] j;
        p = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = ptr + IDX_W'(i);
            if (req[j]) begin
                p.hit = 1'b1;
                p.idx = j;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arb8_if.sv
// Client-side bundle of the arbiter: enable, request lines and grant outputs.
// master = client cluster, slave = arbiter.
interface rr_arb8_if;
    import rr_arb8_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             timeout;

    modport master (output en, req, input gnt, gnt_idx, gnt_vld, timeout);
    modport slave  (input en, req, output gnt, gnt_idx, gnt_vld, timeout);

endinterface

// File: rtl/dec3to8_case.sv
// Shared 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module dec3to8_case (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        if (en) begin
            case (in)
                3'd0: out = 8'h01;
                3'd1: out = 8'h02;
                3'd2: out = 8'h04;
                3'd3: out = 8'h08;
                3'd4: out = 8'h10;
                3'd5: out = 8'h20;
                3'd6: out = 8'h40;
                3'd7: out = 8'h80;
            endcase
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Eight-requester round-robin arbiter with hold-until-release grants.
// Define ARB_TIMEOUT_EN to force-release grants held longer than HOLD_MAX cycles.
module rr_arb8
    import rr_arb8_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
)
`endif
(
    input  logic     clk,
    input  logic     rst_n,
    rr_arb8_if.slave bus
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] gnt;
    logic             gnt_vld;
    pick_t            win;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
`endif

    assign win     = rr_pick(bus.req, ptr_q);
    assign gnt_vld = (state_q == ST_GRANT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.en && win.hit) begin
                    state_d = ST_GRANT;
                    idx_d   = win.idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                // Releasing moves the served client to lowest priority.
                if (!bus.en || !bus.req[idx_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + IDX_W'(1);
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + IDX_W'(1);
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    dec3to8_case u_dec (
        .in  (idx_q),
        .en  (gnt_vld),
        .out (gnt)
    );

    assign bus.gnt     = gnt;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = gnt_vld;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = tmo_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: directed scenarios plus random traffic,
// every cycle compared against a queue-free behavioural arbiter model.
module tb_rr_arb8;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO  = 1;
    localparam int HOLD = 4;
`else
    localparam int TMO  = 0;
    localparam int HOLD = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arb8_if bus ();

`ifdef ARB_TIMEOUT_EN
    rr_arb8 #(.HOLD_MAX(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    rr_arb8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // reference state: who holds the resource, where the search starts next
    int m_busy, m_idx, m_ptr, m_cnt, m_tmo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_tmo = 0;
    endtask

    task automatic model_step();
        m_tmo = 0;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (bus.en && bus.req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    automatic int j = (m_ptr + k) % 8;
                    if (bus.req[j]) begin
                        m_busy = 1; m_idx = j; m_cnt = 1;
                        break;
                    end
                end
            end
        end else if (!bus.en || !bus.req[m_idx]) begin
            m_busy = 0; m_ptr = (m_idx + 1) % 8;
        end else if (TMO != 0 && m_cnt == HOLD) begin
            m_busy = 0; m_ptr = (m_idx + 1) % 8; m_tmo = 1;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check_all();
        logic [7:0] eg;
        eg = (m_busy != 0) ? (8'h01 << m_idx) : 8'h00;
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("gnt_vld", 32'(bus.gnt_vld), 32'(m_busy));
        chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_idx));
        chk("timeout", 32'(bus.timeout), 32'(m_tmo));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = 8'h00;
        bus.en = 1'b1;
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] dropped;
        int order[$];
        int run, tmo_n, inrun;
        int exp_order[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

        model_reset();
        bus.en = 1'b1;
        bus.req = 8'hFF;

        // reset holds everything off even with all requests up
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'h00);
        chk("rst_vld", 32'(bus.gnt_vld), 32'h0);
        chk("rst_idx", 32'(bus.gnt_idx), 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("rst_first", 32'(bus.gnt), 32'h01);

        // rotation: each holder drops after 3 grant cycles, re-raises next cycle
        order.push_back(int'(bus.gnt_idx));
        dropped = 8'h00;
        for (int c = 0; c < 60 && order.size() < 9; c++) begin
            bus.req = bus.req | dropped;
            dropped = 8'h00;
            if (m_busy != 0 && m_cnt == 3) begin
                dropped[m_idx] = 1'b1;
                bus.req[m_idx] = 1'b0;
            end
            cyc();
            if (m_busy != 0 && m_cnt == 1) order.push_back(int'(bus.gnt_idx));
        end
        chk("rot_count", 32'(order.size()), 32'd9);
        for (int i = 0; i < 9 && i < order.size(); i++)
            chk("rot_order", 32'(order[i]), 32'(exp_order[i]));

        // wrap/skip: ptr=6 after client 5, then 0 wins over 2
        apply_reset();
        bus.req = 8'h20; cyc(); cyc();
        bus.req = 8'h00; cyc();
        bus.req = 8'h05; cyc();
        chk("wrap_gnt", 32'(bus.gnt), 32'h01);
        bus.req = 8'h04; cyc(); cyc();
        chk("skip_gnt", 32'(bus.gnt), 32'h04);

        // enable revokes and blocks, then resumes from advanced pointer
        apply_reset();
        bus.req = 8'h08; cyc();
        chk("en_gnt3", 32'(bus.gnt), 32'h08);
        bus.en = 1'b0; cyc();
        chk("en_revoke", 32'(bus.gnt), 32'h00);
        bus.req = 8'hFF;
        repeat (3) cyc();
        chk("en_block", 32'(bus.gnt_vld), 32'h0);
        bus.en = 1'b1; cyc();
        chk("en_resume", 32'(bus.gnt), 32'h10);

        // asynchronous reset between edges drops the grant at once
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(bus.gnt), 32'h00);
        chk("async_vld", 32'(bus.gnt_vld), 32'h0);
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cyc();
        chk("post_rst", 32'(bus.gnt), 32'h01);

        // long hold: bounded only when the timeout build is used
        apply_reset();
        bus.req = 8'h0C; cyc();
        run = 1; inrun = 1; tmo_n = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (inrun != 0 && bus.gnt_vld && bus.gnt_idx == 3'd2) run++;
            else inrun = 0;
            if (bus.timeout) tmo_n++;
        end
        chk("hold_len", 32'(run), (TMO != 0) ? 32'(HOLD) : 32'd21);
        chk("tmo_seen", 32'(tmo_n != 0), 32'(TMO));

        // random traffic obeying hold-until-release
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (!bus.req[i]) begin
                    if ($urandom_range(0, 5) == 0) bus.req[i] = 1'b1;
                end else if (m_busy != 0 && m_idx == i) begin
                    if ($urandom_range(0, 3) == 0) bus.req[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 24) == 0) bus.en = ~bus.en;
            if (!bus.en && $urandom_range(0, 2) == 0) bus.en = 1'b1;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
